// File: rtl/cam_axis_pkg.sv
// Shared types and constants for the camera AXIS frame sanitizer.
package cam_axis_pkg;

  // Sanitizer FSM states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PASS      = 3'd1,
    PAD       = 3'd2,
    DROP_LINE = 3'd3,
    TAIL      = 3'd4
  } state_e;

  // Default pixel value driven on padded pixels.
  localparam logic [23:0] FILL_VALUE_DEF = 24'h000000;

  // Bit of tuser that carries start-of-frame.
  localparam int unsigned SOF_BIT = 0;

endpackage

// File: rtl/axis_out_reg.sv
// One-entry registered AXI4-Stream output stage with a load enable.
// Handshake: a beat transfers on a clock edge where tvalid and tready are both
// high; tvalid, once raised, holds with stable payload until that transfer.
module axis_out_reg #(
  parameter int unsigned           DATA_WIDTH = 24,
  parameter int unsigned           USER_WIDTH = 1,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  output logic                  can_load,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic                  in_tlast,
  input  logic [USER_WIDTH-1:0] in_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser
);

  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [USER_WIDTH-1:0] tuser_q, tuser_d;

  // The slot is free when empty or when its beat leaves this cycle; the
  // caller asserts load only when can_load is high.
  always_comb begin
    can_load = ~tvalid_q | m_axis_tready;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    if (load) begin
      tdata_d  = in_tdata;
      tvalid_d = 1'b1;
      tlast_d  = in_tlast;
      tuser_d  = in_tuser;
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  // Output stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdata_q  <= FILL_VALUE;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= '0;
    end else begin
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;

endmodule

// File: rtl/cam_axis_frame_sanitizer.sv
// Forces a tuser=SoF / tlast=EoL video stream into frames of exactly
// cfg_width x cfg_height: pads short lines, truncates long lines, drops
// pre-SoF data and surplus lines, and reports geometry errors.
// Input handshake: a beat is consumed on a clock edge where s_axis_tvalid and
// s_axis_tready are both high; an unaccepted (held) beat must stay on the bus.
module cam_axis_frame_sanitizer
  import cam_axis_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 24,
  parameter int unsigned           USER_WIDTH = 1,
  parameter int unsigned           XW         = 12,
  parameter int unsigned           YW         = 12,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = DATA_WIDTH'(FILL_VALUE_DEF)
) (
  input  logic                  axis_clk,
  input  logic                  rst,
  input  logic [XW-1:0]         cfg_width,
  input  logic [YW-1:0]         cfg_height,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  err_short_line,
  output logic                  err_long_line,
  output logic                  err_frame,
  output logic [15:0]           frame_cnt
);

  // FSM state; kept as a named flop so checkers can bind to it.
  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [XW-1:0]   w_q, w_d;
  logic [YW-1:0]   h_q, h_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            restart_q, restart_d;   // early SoF waits for padding to finish
  logic            tail_err_q, tail_err_d; // err_frame already raised in this TAIL
  logic            run_q;                  // low only while/after reset until first clock
  logic            err_short_q, err_short_d;
  logic            err_long_q, err_long_d;
  logic            err_frame_q, err_frame_d;

  logic                  can_load;
  logic                  out_load;
  logic [DATA_WIDTH-1:0] out_tdata;
  logic                  out_tlast;
  logic                  out_sof;
  logic [USER_WIDTH-1:0] out_tuser;

  logic          sof_in;
  logic          cfg_zero;
  logic          early;
  logic          s_ready;
  logic          take_pix;
  logic          line_done;
  logic          x_end;
  logic          y_end;
  logic          pad_end;
  logic [XW-1:0] cur_w;
  logic [YW-1:0] cur_h;

  assign sof_in   = s_axis_tuser[SOF_BIT];
  assign cfg_zero = (cfg_width == '0) | (cfg_height == '0);

  // Next-state, counter and output-beat logic.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    w_d         = w_q;
    h_d         = h_q;
    frame_cnt_d = frame_cnt_q;
    restart_d   = restart_q;
    tail_err_d  = tail_err_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    err_frame_d = 1'b0;
    s_ready     = 1'b0;
    out_load    = 1'b0;
    out_tdata   = FILL_VALUE;
    out_tlast   = 1'b0;
    out_sof     = 1'b0;
    take_pix    = 1'b0;
    line_done   = 1'b0;
    cur_w       = w_q;
    cur_h       = h_q;
    early       = sof_in & ((x_q != '0) | (y_q != '0));
    pad_end     = (x_q == w_q - XW'(1));

    case (state_q)
      IDLE, TAIL: begin
        // Non-SoF beats always drain; an SoF needs room in the output stage
        // unless the geometry is zero and it will be discarded anyway.
        s_ready = run_q & (~sof_in | can_load | cfg_zero);
        if (s_axis_tvalid & s_ready) begin
          if (sof_in & ~cfg_zero) begin
            w_d      = cfg_width;
            h_d      = cfg_height;
            cur_w    = cfg_width;
            cur_h    = cfg_height;
            take_pix = 1'b1;
            out_sof  = 1'b1;
          end else if (sof_in) begin
            state_d = IDLE;
          end else if ((state_q == TAIL) && !tail_err_q) begin
            err_frame_d = 1'b1;
            tail_err_d  = 1'b1;
          end
        end
      end

      PASS: begin
        s_ready = ~early & can_load;
        if (s_axis_tvalid & early) begin
          // Early SoF: leave it on the bus, close the current line if needed.
          err_frame_d = 1'b1;
          if (x_q != '0) begin
            restart_d = 1'b1;
            state_d   = PAD;
          end else begin
            y_d     = '0;
            state_d = IDLE;
          end
        end else if (s_axis_tvalid & s_ready) begin
          take_pix = 1'b1;
        end
      end

      PAD: begin
        if (can_load) begin
          out_load  = 1'b1;
          out_tlast = pad_end;
          if (pad_end) line_done = 1'b1;
          else         x_d = x_q + XW'(1);
        end
      end

      DROP_LINE: begin
        s_ready = ~sof_in;
        if (s_axis_tvalid & sof_in) begin
          // Output line is already complete; only a short frame is an error.
          if (y_q == h_q - YW'(1)) begin
            line_done = 1'b1;
          end else begin
            err_frame_d = 1'b1;
            x_d         = '0;
            y_d         = '0;
            state_d     = IDLE;
          end
        end else if (s_axis_tvalid & s_axis_tlast) begin
          line_done = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    x_end = (x_q == cur_w - XW'(1));
    y_end = (y_q == cur_h - YW'(1));

    // Forward one real pixel and classify how its line ends.
    if (take_pix) begin
      out_load  = 1'b1;
      out_tdata = s_axis_tdata;
      out_tlast = x_end;
      state_d   = PASS;
      if (x_end) begin
        if (s_axis_tlast) begin
          line_done = 1'b1;
        end else begin
          err_long_d = 1'b1;
          state_d    = DROP_LINE;
        end
      end else begin
        x_d = x_q + XW'(1);
        if (s_axis_tlast) begin
          err_short_d = 1'b1;
          state_d     = PAD;
        end
      end
    end

    // Common line-end bookkeeping for PASS, PAD and DROP_LINE.
    if (line_done) begin
      x_d = '0;
      if (y_end) frame_cnt_d = frame_cnt_q + 16'd1;
      if (restart_q) begin
        restart_d = 1'b0;
        y_d       = '0;
        state_d   = IDLE;
      end else if (y_end) begin
        y_d        = '0;
        tail_err_d = 1'b0;
        state_d    = TAIL;
      end else begin
        y_d     = y_q + YW'(1);
        state_d = PASS;
      end
    end

    out_tuser          = '0;
    out_tuser[SOF_BIT] = out_sof;
    s_axis_tready      = s_ready;
  end

  // State, counters, latched geometry and error pulses.
  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      frame_cnt_q <= '0;
      restart_q   <= 1'b0;
      tail_err_q  <= 1'b0;
      run_q       <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      w_q         <= w_d;
      h_q         <= h_d;
      frame_cnt_q <= frame_cnt_d;
      restart_q   <= restart_d;
      tail_err_q  <= tail_err_d;
      run_q       <= 1'b1;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      err_frame_q <= err_frame_d;
    end
  end

  axis_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .USER_WIDTH (USER_WIDTH),
    .FILL_VALUE (FILL_VALUE)
  ) u_out (
    .clk           (axis_clk),
    .rst           (rst),
    .load          (out_load),
    .can_load      (can_load),
    .in_tdata      (out_tdata),
    .in_tlast      (out_tlast),
    .in_tuser      (out_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser)
  );

  assign err_short_line = err_short_q;
  assign err_long_line  = err_long_q;
  assign err_frame      = err_frame_q;
  assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_cam_axis_frame_sanitizer.sv
// Directed testbench for cam_axis_frame_sanitizer.
module tb_cam_axis_frame_sanitizer;

  localparam int BW = 26; // {tuser, tlast, tdata}

  logic        clk;
  logic        rst;
  logic [11:0] cfg_width;
  logic [11:0] cfg_height;
  logic [23:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [0:0]  s_tuser;
  logic [23:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [0:0]  m_tuser;
  logic        err_short_line;
  logic        err_long_line;
  logic        err_frame;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got_q[$];
  int            n_short, n_long, n_frame;
  logic          stall_pend;
  logic [BW-1:0] stall_data;
  int            stall_seen, stall_bad;

  cam_axis_frame_sanitizer dut (
    .axis_clk       (clk),
    .rst            (rst),
    .cfg_width      (cfg_width),
    .cfg_height     (cfg_height),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .s_axis_tlast   (s_tlast),
    .s_axis_tuser   (s_tuser),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tlast   (m_tlast),
    .m_axis_tuser   (m_tuser),
    .err_short_line (err_short_line),
    .err_long_line  (err_long_line),
    .err_frame      (err_frame),
    .frame_cnt      (frame_cnt)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Output monitor and stall checker, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid && m_tready) got_q.push_back({m_tuser[0], m_tlast, m_tdata});
      if (err_short_line) n_short++;
      if (err_long_line)  n_long++;
      if (err_frame)      n_frame++;
      if (stall_pend && !(m_tvalid && ({m_tuser[0], m_tlast, m_tdata} === stall_data)))
        stall_bad++;
      stall_pend = m_tvalid && !m_tready;
      stall_data = {m_tuser[0], m_tlast, m_tdata};
      if (stall_pend) stall_seen++;
    end else begin
      stall_pend = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    got_q.delete();
    exp_q.delete();
    n_short    = 0;
    n_long     = 0;
    n_frame    = 0;
    stall_seen = 0;
    stall_bad  = 0;
  endtask

  task automatic send(input logic [23:0] d, input logic u, input logic l);
    int   n;
    logic acc;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout data=%h: s_axis_tready never seen", d);
    end
  endtask

  task automatic exp_beat(input logic u, input logic l, input logic [23:0] d);
    exp_q.push_back({u, l, d});
  endtask

  task automatic wait_out(input int n);
    int c;
    c = 0;
    while (got_q.size() < n && c < 300) begin
      @(posedge clk);
      #1;
      c++;
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic send_clean_4x2();
    for (int i = 0; i < 8; i++)
      send(24'h100000 + 24'(i), (i == 0), (i % 4 == 3));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst      = 1'b1;
    s_tvalid = 1'b1;
    s_tuser  = 1'b1;
    s_tdata  = 24'hABCDEF;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
    total++; if (m_tdata !== 24'h0) begin bad++; $display("FAIL reset_tdata got=%h exp=000000", m_tdata); end
    total++; if (m_tlast !== 1'b0 || m_tuser !== 1'b0) begin bad++; $display("FAIL reset_tlast_tuser got=%b%b exp=00", m_tlast, m_tuser); end
    total++; if ({err_short_line, err_long_line, err_frame} !== 3'b000) begin bad++; $display("FAIL reset_err got=%b exp=000", {err_short_line, err_long_line, err_frame}); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_s_tready got=%b exp=0", s_tready); end
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic test_clean_frame();
    apply_reset();
    cfg_width  = 12'd4;
    cfg_height = 12'd2;
    for (int i = 0; i < 8; i++) exp_beat((i == 0), (i % 4 == 3), 24'h100000 + 24'(i));
    send_clean_4x2();
    wait_out(8);
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL clean_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL clean_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL clean_frame_cnt got=%0d exp=1", frame_cnt); end
    total++; if (n_short + n_long + n_frame !== 0) begin bad++; $display("FAIL clean_errs got=%0d/%0d/%0d exp=0/0/0", n_short, n_long, n_frame); end
  endtask

  task automatic test_short_line();
    apply_reset();
    cfg_width  = 12'd4;
    cfg_height = 12'd1;
    exp_beat(1'b1, 1'b0, 24'h0000AA);
    exp_beat(1'b0, 1'b0, 24'h0000BB);
    exp_beat(1'b0, 1'b0, 24'h000000);
    exp_beat(1'b0, 1'b1, 24'h000000);
    send(24'h0000AA, 1'b1, 1'b0);
    send(24'h0000BB, 1'b0, 1'b1);
    wait_out(4);
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL short_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL short_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    total++; if (n_short !== 1 || n_long !== 0 || n_frame !== 0) begin bad++; $display("FAIL short_errs got=%0d/%0d/%0d exp=1/0/0", n_short, n_long, n_frame); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL short_frame_cnt got=%0d exp=1", frame_cnt); end
  endtask

  task automatic test_long_line();
    apply_reset();
    cfg_width  = 12'd4;
    cfg_height = 12'd1;
    for (int i = 0; i < 4; i++) exp_beat((i == 0), (i == 3), 24'h200000 + 24'(i));
    for (int i = 0; i < 6; i++) send(24'h200000 + 24'(i), (i == 0), (i == 5));
    wait_out(4);
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL long_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL long_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    total++; if (n_short !== 0 || n_long !== 1 || n_frame !== 0) begin bad++; $display("FAIL long_errs got=%0d/%0d/%0d exp=0/1/0", n_short, n_long, n_frame); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL long_frame_cnt got=%0d exp=1", frame_cnt); end
  endtask

  task automatic test_no_sof();
    apply_reset();
    // SoF under a zero geometry is drained, not started.
    cfg_width  = 12'd0;
    cfg_height = 12'd1;
    send(24'h3000EE, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send(24'h3000F0 + 24'(i), 1'b0, (i == 2));
    cfg_width = 12'd4;
    for (int i = 0; i < 4; i++) exp_beat((i == 0), (i == 3), 24'h300000 + 24'(i));
    for (int i = 0; i < 4; i++) send(24'h300000 + 24'(i), (i == 0), (i == 3));
    wait_out(4);
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL nosof_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL nosof_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    total++; if (n_short + n_long + n_frame !== 0) begin bad++; $display("FAIL nosof_errs got=%0d/%0d/%0d exp=0/0/0", n_short, n_long, n_frame); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL nosof_frame_cnt got=%0d exp=1", frame_cnt); end
  endtask

  task automatic test_early_sof();
    apply_reset();
    cfg_width  = 12'd4;
    cfg_height = 12'd3;
    for (int i = 0; i < 4; i++) exp_beat((i == 0), (i == 3), 24'h400000 + 24'(i));
    exp_beat(1'b0, 1'b0, 24'h400010);
    exp_beat(1'b0, 1'b0, 24'h400011);
    exp_beat(1'b0, 1'b0, 24'h000000);
    exp_beat(1'b0, 1'b1, 24'h000000);
    for (int i = 0; i < 4; i++) exp_beat((i == 0), (i == 3), 24'h400020 + 24'(i));
    for (int i = 0; i < 4; i++) send(24'h400000 + 24'(i), (i == 0), (i == 3));
    send(24'h400010, 1'b0, 1'b0);
    send(24'h400011, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send(24'h400020 + 24'(i), (i == 0), (i == 3));
    wait_out(12);
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL early_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL early_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    total++; if (n_short !== 0 || n_long !== 0 || n_frame !== 1) begin bad++; $display("FAIL early_errs got=%0d/%0d/%0d exp=0/0/1", n_short, n_long, n_frame); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL early_frame_cnt got=%0d exp=0", frame_cnt); end
  endtask

  task automatic test_width_one();
    apply_reset();
    cfg_width  = 12'd1;
    cfg_height = 12'd2;
    exp_beat(1'b1, 1'b1, 24'h500001);
    exp_beat(1'b0, 1'b1, 24'h500002);
    send(24'h500001, 1'b1, 1'b1);
    send(24'h500002, 1'b0, 1'b1);
    wait_out(2);
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL w1_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL w1_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    total++; if (n_short + n_long + n_frame !== 0) begin bad++; $display("FAIL w1_errs got=%0d/%0d/%0d exp=0/0/0", n_short, n_long, n_frame); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL w1_frame_cnt got=%0d exp=1", frame_cnt); end
  endtask

  task automatic test_stall();
    apply_reset();
    cfg_width  = 12'd4;
    cfg_height = 12'd2;
    for (int i = 0; i < 8; i++) exp_beat((i == 0), (i % 4 == 3), 24'h100000 + 24'(i));
    fork
      send_clean_4x2();
      begin
        repeat (60) begin
          @(posedge clk);
          #1;
          m_tready = ~m_tready;
        end
      end
    join
    m_tready = 1'b1;
    wait_out(8);
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL stall_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    total++; if (stall_seen == 0) begin bad++; $display("FAIL stall_seen got=0 exp=>0"); end
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL stall_stable got=%0d unstable cycles exp=0", stall_bad); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL stall_frame_cnt got=%0d exp=1", frame_cnt); end
  endtask

  // Test sequence and final report.
  initial begin
    cfg_width  = 12'd4;
    cfg_height = 12'd2;
    s_tdata    = '0;
    s_tvalid   = 1'b0;
    s_tlast    = 1'b0;
    s_tuser    = 1'b0;
    m_tready   = 1'b1;
    rst        = 1'b1;
    stall_pend = 1'b0;
    stall_data = '0;
    n_short    = 0;
    n_long     = 0;
    n_frame    = 0;
    stall_seen = 0;
    stall_bad  = 0;
    test_reset();
    test_clean_frame();
    test_short_line();
    test_long_line();
    test_no_sof();
    test_early_sof();
    test_width_one();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
